// File: rtl/sm4_iter.sv
// Iterative SM4 block cipher core: RPC rounds per clock, on-chip key expansion
// into a 32-entry round-key file, with optional reuse of the last expanded key.
module sm4_iter #(
  parameter int unsigned RPC       = 1,
  parameter bit          KEY_CACHE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode,
  input  logic [127:0] key,
  input  logic [127:0] din,
  output logic         busy,
  output logic         done,
  output logic [127:0] dout
);

  localparam int unsigned N    = 32 / RPC;
  localparam logic [4:0]  LAST = 5'(N - 1);

  localparam logic [127:0] FK = 128'ha3b1bac656aa3350677d9197b27022dc;

  localparam logic [2047:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  typedef enum logic [1:0] {IDLE, KEYEXP, CRYPT} state_t;

  state_t       state;
  logic [4:0]   cnt;
  logic         mode_q;
  logic [127:0] key_q;
  logic [127:0] din_q;
  logic [127:0] key_st;
  logic         key_valid;
  logic         key_hit;
  logic [31:0]  kreg [4];
  logic [31:0]  xreg [4];
  logic [31:0]  rkf  [32];
  logic [31:0]  kc   [RPC+4];
  logic [31:0]  xc   [RPC+4];
  logic [4:0]   ridx [RPC];

  // Table entry 0 sits in the top byte, so entry a lives at bit (255-a)*8.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [10:0] idx;
    idx = {~a, 3'b000};
    return SBOX[idx +: 8];
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    logic [31:0] t;
    for (int unsigned j = 0; j < 4; j++) t[8*j +: 8] = sbox(a[8*j +: 8]);
    return t;
  endfunction

  function automatic logic [31:0] rol(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] l_enc(input logic [31:0] b);
    return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
  endfunction

  function automatic logic [31:0] l_key(input logic [31:0] b);
    return b ^ rol(b, 13) ^ rol(b, 23);
  endfunction

  // CK byte j of round r is (4r+j)*7 mod 256.
  function automatic logic [31:0] ck_word(input logic [4:0] r);
    logic [31:0] w;
    for (int unsigned j = 0; j < 4; j++) w[8*(3-j) +: 8] = 8'((32'(r) * 4 + j) * 7);
    return w;
  endfunction

  assign busy    = (state != IDLE);
  assign key_hit = KEY_CACHE && key_valid && (key == key_st);

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      kc[i] = kreg[i];
      xc[i] = xreg[i];
    end
    for (int unsigned j = 0; j < RPC; j++) begin
      ridx[j]  = 5'(32'(cnt) * RPC + j);
      kc[j+4]  = kc[j] ^ l_key(tau(kc[j+1] ^ kc[j+2] ^ kc[j+3] ^ ck_word(ridx[j])));
      // Decrypt walks the key file backwards; 31-i is the bitwise inverse of i.
      xc[j+4]  = xc[j] ^ l_enc(tau(xc[j+1] ^ xc[j+2] ^ xc[j+3] ^
                                   rkf[mode_q ? ~ridx[j] : ridx[j]]));
    end
  end

  always_ff @(posedge clk) begin
    if (state == KEYEXP) begin
      for (int unsigned j = 0; j < RPC; j++) rkf[ridx[j]] <= kc[j+4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mode_q    <= 1'b0;
      key_q     <= '0;
      din_q     <= '0;
      key_st    <= '0;
      key_valid <= 1'b0;
      done      <= 1'b0;
      dout      <= '0;
      kreg      <= '{default: '0};
      xreg      <= '{default: '0};
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mode_q <= mode;
            key_q  <= key;
            din_q  <= din;
            cnt    <= '0;
            if (key_hit) begin
              state <= CRYPT;
              for (int unsigned i = 0; i < 4; i++) xreg[i] <= din[127-32*i -: 32];
            end else begin
              state     <= KEYEXP;
              key_valid <= 1'b0;
              for (int unsigned i = 0; i < 4; i++)
                kreg[i] <= key[127-32*i -: 32] ^ FK[127-32*i -: 32];
            end
          end
        end
        KEYEXP: begin
          for (int unsigned i = 0; i < 4; i++) kreg[i] <= kc[RPC+i];
          cnt <= cnt + 5'd1;
          if (cnt == LAST) begin
            state     <= CRYPT;
            cnt       <= '0;
            key_valid <= 1'b1;
            key_st    <= key_q;
            for (int unsigned i = 0; i < 4; i++) xreg[i] <= din_q[127-32*i -: 32];
          end
        end
        CRYPT: begin
          for (int unsigned i = 0; i < 4; i++) xreg[i] <= xc[RPC+i];
          cnt <= cnt + 5'd1;
          if (cnt == LAST) begin
            dout  <= {xc[RPC+3], xc[RPC+2], xc[RPC+1], xc[RPC]};
            done  <= 1'b1;
            state <= IDLE;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm4_iter.sv
// Directed bench for sm4_iter: standard SM4 vector across RPC variants, key
// caching, ignored starts, mid-operation reset and back-to-back requests.
module tb_sm4_iter;

  localparam logic [127:0] K  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] P  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] C  = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] K2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] P2 = 128'hdeadbeefcafef00d0badc0de12345678;

  logic         clk = 1'b0;
  logic         rst0, rst1;
  logic         start0, start1, start2;
  logic         mode;
  logic [127:0] key, din;
  logic         busy0, busy2, busy4, busy8, busync;
  logic         done0, done2, done4, done8, donenc;
  logic [127:0] dout0, dout2, dout4, dout8, doutnc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sm4_iter #(.RPC(1), .KEY_CACHE(1'b1)) dut_r1 (
    .clk(clk), .rst_n(rst0), .start(start0), .mode(mode), .key(key), .din(din),
    .busy(busy0), .done(done0), .dout(dout0));
  sm4_iter #(.RPC(2), .KEY_CACHE(1'b1)) dut_r2 (
    .clk(clk), .rst_n(rst1), .start(start1), .mode(mode), .key(key), .din(din),
    .busy(busy2), .done(done2), .dout(dout2));
  sm4_iter #(.RPC(4), .KEY_CACHE(1'b1)) dut_r4 (
    .clk(clk), .rst_n(rst1), .start(start1), .mode(mode), .key(key), .din(din),
    .busy(busy4), .done(done4), .dout(dout4));
  sm4_iter #(.RPC(8), .KEY_CACHE(1'b1)) dut_r8 (
    .clk(clk), .rst_n(rst1), .start(start1), .mode(mode), .key(key), .din(din),
    .busy(busy8), .done(done8), .dout(dout8));
  sm4_iter #(.RPC(2), .KEY_CACHE(1'b0)) dut_nc (
    .clk(clk), .rst_n(rst1), .start(start2), .mode(mode), .key(key), .din(din),
    .busy(busync), .done(donenc), .dout(doutnc));

  typedef struct {
    logic         m;
    logic [127:0] k;
    logic [127:0] d;
    logic [127:0] exp;
    logic         chk;
    int           lat;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_main(input logic m, input logic [127:0] k, input logic [127:0] d,
                          output int lat, output logic b, output logic [127:0] res);
    @(negedge clk);
    mode = m; key = k; din = d; start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    b   = busy0;
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (done0) begin
        lat = c;
        break;
      end
    end
    res = dout0;
  endtask

  task automatic run_aux(input logic m, input logic [127:0] k, input logic [127:0] d,
                         output int l2, output int l4, output int l8,
                         output logic [127:0] o2, output logic [127:0] o4,
                         output logic [127:0] o8);
    @(negedge clk);
    mode = m; key = k; din = d; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    l2 = -1; l4 = -1; l8 = -1;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk);
      #1;
      if (done2 && l2 < 0) l2 = c;
      if (done4 && l4 < 0) l4 = c;
      if (done8 && l8 < 0) l8 = c;
    end
    o2 = dout2; o4 = dout4; o8 = dout8;
  endtask

  initial begin
    int           lat, l2, l4, l8, ndone, first;
    logic         b;
    logic [127:0] res, o2, o4, o8;

    tbl[0] = '{1'b0, K,  P, C, 1'b1, 64};
    tbl[1] = '{1'b1, K,  C, P, 1'b1, 32};
    tbl[2] = '{1'b0, K,  P, C, 1'b1, 32};
    tbl[3] = '{1'b1, K2, C, '0, 1'b0, 64};
    tbl[4] = '{1'b1, K,  C, P, 1'b1, 64};
    tbl[5] = '{1'b0, K,  P, C, 1'b1, 32};

    rst0 = 1'b0; rst1 = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    mode = 1'b0; key = '0; din = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 128'(busy0), 128'(0));
    chk("rst_done", 128'(done0), 128'(0));
    chk("rst_dout", dout0, '0);
    rst0 = 1'b1; rst1 = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_main(tbl[i].m, tbl[i].k, tbl[i].d, lat, b, res);
      chk($sformatf("v%0d_lat", i), 128'(lat), 128'(tbl[i].lat));
      chk($sformatf("v%0d_busy", i), 128'(b), 128'(1));
      if (tbl[i].chk) chk($sformatf("v%0d_dout", i), res, tbl[i].exp);
      if (i == 0) begin
        chk("rk0",  128'(dut_r1.rkf[0]),  128'(32'hf12186f9));
        chk("rk31", 128'(dut_r1.rkf[31]), 128'(32'h9124a012));
      end
    end

    // Fresh key expansion with stray starts and input churn while busy.
    rst0 = 1'b0;
    @(negedge clk);
    rst0 = 1'b1;
    @(negedge clk);
    mode = 1'b0; key = K; din = P; start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    ndone = 0; first = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      if (done0) begin
        ndone++;
        if (first < 0) first = c;
      end
      start0 = (c == 4 || c == 39);
      if (c == 4 || c == 20 || c == 39) begin
        mode = 1'b1; key = K2; din = P2;
      end
    end
    start0 = 1'b0;
    chk("ign_first", 128'(first), 128'(64));
    chk("ign_count", 128'(ndone), 128'(1));
    chk("ign_dout", dout0, C);

    // Reset in the middle of a cached CRYPT run.
    @(negedge clk);
    mode = 1'b0; key = K; din = P; start0 = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst0 = 1'b0;
    #1;
    chk("mid_busy", 128'(busy0), 128'(0));
    chk("mid_done", 128'(done0), 128'(0));
    chk("mid_dout", dout0, '0);
    @(posedge clk);
    #1 rst0 = 1'b1;
    ndone = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (done0) ndone++;
    end
    chk("mid_nodone", 128'(ndone), 128'(0));
    run_main(1'b0, K, P, lat, b, res);
    chk("mid_rerun_lat", 128'(lat), 128'(64));
    chk("mid_rerun_dout", res, C);

    // Decrypt round trip under a second key.
    run_main(1'b0, K2, P2, lat, b, res);
    chk("k2_enc_lat", 128'(lat), 128'(64));
    run_main(1'b1, K2, res, lat, b, res);
    chk("k2_dec_lat", 128'(lat), 128'(32));
    chk("k2_dec_dout", res, P2);

    // Wider datapaths: same vector, then cached decrypt.
    run_aux(1'b0, K, P, l2, l4, l8, o2, o4, o8);
    chk("r2_lat", 128'(l2), 128'(32));
    chk("r4_lat", 128'(l4), 128'(16));
    chk("r8_lat", 128'(l8), 128'(8));
    chk("r2_dout", o2, C);
    chk("r4_dout", o4, C);
    chk("r8_dout", o8, C);
    run_aux(1'b1, K, C, l2, l4, l8, o2, o4, o8);
    chk("r2_dec_lat", 128'(l2), 128'(16));
    chk("r4_dec_lat", 128'(l4), 128'(8));
    chk("r8_dec_lat", 128'(l8), 128'(4));
    chk("r2_dec_dout", o2, P);
    chk("r4_dec_dout", o4, P);
    chk("r8_dec_dout", o8, P);

    // No cache: back-to-back with the second start in the done cycle.
    @(negedge clk);
    mode = 1'b0; key = K; din = P; start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      if (donenc) begin
        lat = c;
        break;
      end
    end
    chk("nc1_lat", 128'(lat), 128'(32));
    chk("nc1_dout", doutnc, C);
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    chk("nc_done_drop", 128'(donenc), 128'(0));
    chk("nc2_busy", 128'(busync), 128'(1));
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      if (donenc) begin
        lat = c;
        break;
      end
    end
    chk("nc2_lat", 128'(lat), 128'(32));
    chk("nc2_dout", doutnc, C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
